// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop sync, tick-sampled debounce, sticky press flags, registered IO read port.
// Define IO_BTN_IRQ_EN to add the irq output (OR of press flags, delayed one cycle).
module io_input_conditioner #(
  parameter int TICK_DIV       = 100000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [15:0] sw_level,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_pressed
`ifdef IO_BTN_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int NB = 21;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_MAX   = 4'(STABLE_SAMPLES - 1);

  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [3:0]    cnt_r [NB];
  logic [3:0]    cnt_nxt_s [NB];
  logic [NB-1:0] level_r;
  logic [NB-1:0] level_nxt_s;
  logic [4:0]    btn_rise_s;
  logic [4:0]    pressed_r;
  logic [4:0]    pressed_nxt_s;
  logic          rd_clr_s;
  logic [31:0]   rd_mux_s;
  logic [31:0]   rd_data_r;

  assign tick_s     = (presc_r == PRESC_MAX);
  assign rd_clr_s   = rd_en && (rd_addr == 2'b11);
  assign btn_rise_s = level_nxt_s[20:16] & ~level_r[20:16];

  assign sw_level    = level_r[15:0];
  assign btn_level   = level_r[20:16];
  assign btn_pressed = pressed_r;
  assign rd_data     = rd_data_r;

  // Input synchronisers and debounce sample prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      presc_r <= '0;
    end else begin
      sync1_r <= {btn_in, sw_in};
      sync2_r <= sync1_r;
      if (tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Per-bit debounce: a level flips on the STABLE_SAMPLES-th consecutive differing tick
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < NB; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
    end
    if (tick_s) begin
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          cnt_nxt_s[i] = 4'd0;
        end else if (cnt_r[i] >= CNT_MAX) begin
          level_nxt_s[i] = ~level_r[i];
          cnt_nxt_s[i]   = 4'd0;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + 4'd1;
        end
      end
    end else begin
      level_nxt_s = level_r;
    end
  end

  // A press arriving on a clearing read survives, so no event is ever lost
  always_comb begin
    if (rd_clr_s) begin
      pressed_nxt_s = btn_rise_s;
    end else begin
      pressed_nxt_s = pressed_r | btn_rise_s;
    end
  end

  // Read address decode
  always_comb begin
    case (rd_addr)
      2'b00:   rd_mux_s = 32'd0;
      2'b01:   rd_mux_s = {16'd0, level_r[15:0]};
      2'b10:   rd_mux_s = {27'd0, level_r[20:16]};
      2'b11:   rd_mux_s = {27'd0, pressed_r};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Debounce state, press flags and read data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r   <= '0;
      pressed_r <= 5'd0;
      rd_data_r <= 32'd0;
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else begin
      level_r   <= level_nxt_s;
      pressed_r <= pressed_nxt_s;
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      if (rd_en) begin
        rd_data_r <= rd_mux_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

`ifdef IO_BTN_IRQ_EN
  logic irq_r;

  // Interrupt follows the press flags one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |pressed_r;
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed plan items plus random stimulus against a sample-history model.
module tb_io_input_conditioner;
  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] sw_level;
  logic [4:0]  btn_level;
  logic [4:0]  btn_pressed;
`ifdef IO_BTN_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  io_input_conditioner #(.TICK_DIV(TICK_DIV), .STABLE_SAMPLES(STABLE)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .sw_level(sw_level), .btn_level(btn_level), .btn_pressed(btn_pressed)
`ifdef IO_BTN_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last STABLE tick samples all disagree with it
  logic [20:0] m_s1, m_s2, m_level, m_flip, m_nl;
  logic [20:0] m_hist [STABLE];
  logic [4:0]  m_pressed, m_rise;
  logic [31:0] m_rd;
  logic        m_irq;
  int          m_edges;
  logic        m_tick;

  assign m_tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
  assign m_nl   = m_level ^ m_flip;
  assign m_rise = m_nl[20:16] & ~m_level[20:16];

  always_comb begin
    m_flip = '0;
    if (m_tick) begin
      for (int b = 0; b < 21; b++) begin
        m_flip[b] = (m_s2[b] != m_level[b]);
        for (int k = 0; k < STABLE - 1; k++) begin
          m_flip[b] = m_flip[b] & (m_hist[k][b] != m_level[b]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_pressed <= '0; m_rd <= '0; m_irq <= 1'b0; m_edges <= 0;
      for (int k = 0; k < STABLE; k++) m_hist[k] <= '0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_tick) begin
        m_hist[0] <= m_s2;
        for (int k = 1; k < STABLE; k++) m_hist[k] <= m_hist[k-1];
      end
      if (rd_en) begin
        case (rd_addr)
          2'b01:   m_rd <= {16'd0, m_level[15:0]};
          2'b10:   m_rd <= {27'd0, m_level[20:16]};
          2'b11:   m_rd <= {27'd0, m_pressed};
          default: m_rd <= 32'd0;
        endcase
      end
      m_pressed <= ((rd_en && rd_addr == 2'b11) ? 5'd0 : m_pressed) | m_rise;
      m_irq     <= |m_pressed;
      m_level   <= m_nl;
      m_s2      <= m_s1;
      m_s1      <= {btn_in, sw_in};
    end
  end

  always @(negedge clk) begin
    check("rd_data",     rd_data,                 m_rd);
    check("sw_level",    {16'd0, sw_level},       {16'd0, m_level[15:0]});
    check("btn_level",   {27'd0, btn_level},      {27'd0, m_level[20:16]});
    check("btn_pressed", {27'd0, btn_pressed},    {27'd0, m_pressed});
`ifdef IO_BTN_IRQ_EN
    check("irq",         {31'd0, irq},            {31'd0, m_irq});
`endif
  end

  task automatic do_read(input logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_in = 16'hFFFF; btn_in = 5'd0; rd_en = 1'b0; rd_addr = 2'b00;
    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_sw_level", {16'd0, sw_level}, 32'd0);
    check("rst_btn", {22'd0, btn_level, btn_pressed}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 14 && sw_level != 16'hFFFF; i++) @(negedge clk);
    check("rst_release_sw", {16'd0, sw_level}, 32'h0000FFFF);
    check("rst_release_press", {27'd0, btn_pressed}, 32'd0);

    // 2. glitch reject, then a real press
    btn_in[0] = 1'b1; repeat (6) @(negedge clk);
    btn_in[0] = 1'b0; repeat (20) @(negedge clk);
    check("glitch_level", {27'd0, btn_level}, 32'd0);
    check("glitch_press", {27'd0, btn_pressed}, 32'd0);
    btn_in[0] = 1'b1; repeat (20) @(negedge clk);
    check("hold_level0", {31'd0, btn_level[0]}, 32'd1);
    check("hold_press0", {31'd0, btn_pressed[0]}, 32'd1);

    // 3. read map
    sw_in = 16'hA5C3; btn_in = 5'b10010; repeat (20) @(negedge clk);
    do_read(2'b01); check("read_sw", rd_data, 32'h0000A5C3);
    do_read(2'b10); check("read_btn", rd_data, 32'h00000012);
    do_read(2'b00); check("read_zero", rd_data, 32'h00000000);

    // 4. clear-on-read
    do_read(2'b11);
    btn_in = 5'b01000; repeat (20) @(negedge clk);
    do_read(2'b11); check("cor_first", rd_data, 32'h00000008);
    check("cor_flags", {27'd0, btn_pressed}, 32'd0);
    do_read(2'b11); check("cor_second", rd_data, 32'h00000000);

    // 5. collision: btn1 rises on the same edge as a clearing read
    rst = 1'b1; repeat (2) @(negedge clk);
    rst = 1'b0; sw_in = 16'd0; btn_in = 5'b00100;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 4) btn_in[1] = 1'b1;
      if (e == 15) begin rd_en = 1'b1; rd_addr = 2'b11; end
    end
    rd_en = 1'b0;
    check("coll_rd", rd_data, 32'h00000004);
    check("coll_flags", {27'd0, btn_pressed}, 32'h00000002);

`ifdef IO_BTN_IRQ_EN
    // 6. interrupt follows flags
    do_read(2'b11);
    btn_in = 5'b10000;
    for (int i = 0; i < 40 && !btn_pressed[4]; i++) @(negedge clk);
    check("irq_flag4", {31'd0, btn_pressed[4]}, 32'd1);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    rd_en = 1'b1; rd_addr = 2'b11; @(negedge clk); rd_en = 1'b0;
    @(negedge clk);
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, 4)] ^= 1'b1;
      rd_en   = ($urandom_range(0, 3) == 0);
      rd_addr = 2'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
